bram_read_arbiter: RTL



---
 rtl/bram_read_arbiter_pkg.sv | 16 +
 rtl/bram_read_arbiter_if.sv | 34 +++
 rtl/bram_read_arbiter_rr_arbiter.sv | 32 +++
 rtl/bram_read_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bram_read_arbiter_pkg.sv
// Shared definitions for the BRAM read-port arbiter: FSM states, ID width,
// and the default read latency.
package bram_read_arbiter_pkg;

  localparam int ID_W           = 3;
  localparam int RD_LATENCY_DEF = 2;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_read_arbiter_if.sv
// Requester/BRAM bundle for the read arbiter; the arbiter is the slave side,
// requesters and the BRAM together form the master side.
interface bram_read_arbiter_if
  import bram_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len_m1;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic                          bram_en;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_dout;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  id_t                           rd_id;
  logic                          busy;

  modport slave (
    input  req, req_addr, req_len_m1, bram_dout,
    output grant, done, bram_en, bram_addr, rd_data, rd_valid, rd_id, busy
  );

  modport master (
    output req, req_addr, req_len_m1, bram_dout,
    input  grant, done, bram_en, bram_addr, rd_data, rd_valid, rd_id, busy
  );

endinterface

// File: rtl/bram_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after the
// pointer (wrapping) wins. The pointer register lives in the parent.
module rr_arbiter
  import bram_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  id_t                i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output id_t                o_idx,
  output logic               o_any
);

  always_comb begin
    logic found;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && i_req[i] && (i == (int'(i_ptr) + k) % NUM_REQ)) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = id_t'(i);
        end
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of one BRAM read port among burst requesters; returns
// data tagged with the owner ID after the fixed BRAM read latency.
module bram_read_arbiter
  import bram_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bram_read_arbiter_if.slave  bus
);

  state_t                  r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      r_grant;
  id_t                     r_owner;
  id_t                     r_ptr;
  logic                    r_bram_en;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [RD_LATENCY-1:0]   r_vld_p;
  logic [RD_LATENCY-1:0]   r_last_p;
  id_t                     r_id_p [RD_LATENCY];

  logic [NUM_REQ-1:0]      w_gnt;
  id_t                     w_idx;
  id_t                     w_ptr_nxt;
  logic                    w_any;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [ADDR_WIDTH-1:0]   w_sel_len;
  logic                    w_issue_last;
  logic                    w_last_ret;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = w_sel_len  | bus.req_len_m1[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_ptr_nxt    = (w_idx == id_t'(NUM_REQ-1)) ? '0 : w_idx + id_t'(1);
  assign w_issue_last = r_bram_en && (r_cnt == '0);
  // The word tagged last at issue time marks burst completion on return.
  assign w_last_ret   = r_vld_p[RD_LATENCY-1] && r_last_p[RD_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any)          w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (r_cnt == '0)    w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_ret)     w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: grant capture and address/count issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant     <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_gnt;
            r_owner     <= w_idx;
            r_ptr       <= w_ptr_nxt;
            r_bram_en   <= 1'b1;
            r_bram_addr <= w_sel_addr;
            r_cnt       <= w_sel_len;
          end
        end
        ST_ISSUE: begin
          if (r_cnt == '0) begin
            r_bram_en <= 1'b0;
          end else begin
            r_bram_addr <= r_bram_addr + ADDR_WIDTH'(1);
            r_cnt       <= r_cnt - ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (w_last_ret) r_grant <= '0;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  // Stage p1..pN: valid/last/id delay line matching BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p  <= '0;
      r_last_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_id_p[i] <= '0;
    end else begin
      r_vld_p[0]  <= r_bram_en;
      r_last_p[0] <= w_issue_last;
      r_id_p[0]   <= r_owner;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_last_p[i] <= r_last_p[i-1];
        r_id_p[i]   <= r_id_p[i-1];
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = w_last_ret ? r_grant : '0;
  assign bus.bram_en   = r_bram_en;
  assign bus.bram_addr = r_bram_addr;
  assign bus.rd_valid  = r_vld_p[RD_LATENCY-1];
  assign bus.rd_id     = r_id_p[RD_LATENCY-1];
  assign bus.rd_data   = r_vld_p[RD_LATENCY-1] ? bus.bram_dout : {DATA_WIDTH{1'b0}};
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
